// File: rtl/dram0_bank_initiator_if.sv
// Request/response stream bundle and two-bank DataRAM0 port bundle used by dram0_bank_initiator.
interface dram0_req_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 64,
    parameter int unsigned BW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_byte_en;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_byte_en, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_byte_en, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

interface dram0_mem_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 64,
    parameter int unsigned BW = 8
);
    logic [AW-2:0] DRam0AddrB0;
    logic [AW-2:0] DRam0AddrB1;
    logic          DRam0EnB0;
    logic          DRam0EnB1;
    logic          DRam0WrB0;
    logic          DRam0WrB1;
    logic [BW-1:0] DRam0ByteEnB0;
    logic [BW-1:0] DRam0ByteEnB1;
    logic [DW-1:0] DRam0WrDataB0;
    logic [DW-1:0] DRam0WrDataB1;
    logic          DRam0BusyB0;
    logic          DRam0BusyB1;
    logic [DW-1:0] DRam0DataB0;
    logic [DW-1:0] DRam0DataB1;

    modport master (
        output DRam0AddrB0, DRam0AddrB1, DRam0EnB0, DRam0EnB1, DRam0WrB0, DRam0WrB1,
               DRam0ByteEnB0, DRam0ByteEnB1, DRam0WrDataB0, DRam0WrDataB1,
        input  DRam0BusyB0, DRam0BusyB1, DRam0DataB0, DRam0DataB1
    );
    modport slave (
        input  DRam0AddrB0, DRam0AddrB1, DRam0EnB0, DRam0EnB1, DRam0WrB0, DRam0WrB1,
               DRam0ByteEnB0, DRam0ByteEnB1, DRam0WrDataB0, DRam0WrDataB1,
        output DRam0BusyB0, DRam0BusyB1, DRam0DataB0, DRam0DataB1
    );
endinterface

// File: rtl/dram0_bank_initiator.sv
// Steers a valid/ready request stream onto the two DataRAM0 banks and returns read data
// in order through a credit-protected response FIFO.
module dram0_bank_initiator #(
    parameter int unsigned AW        = 15,
    parameter int unsigned DW        = 64,
    parameter int unsigned BW        = 8,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        BReset,
    dram0_req_if.slave  req,
    dram0_mem_if.master mem
);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 3);

    logic          s1_q, s2_q, t1_q, t2_q;
    logic [DW-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          bank;
    logic [AW-2:0] row;
    logic [CW-1:0] outstanding;
    logic          credit_ok;
    logic          busy_sel;
    logic          en;
    logic          accept;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;

    // Credit ignores a same-cycle pop so the FIFO can never be over-subscribed.
    assign bank        = req.req_addr[0];
    assign row         = req.req_addr[AW-1:1];
    assign outstanding = CW'(s1_q) + CW'(s2_q) + count_q;
    assign credit_ok   = req.req_write || (outstanding < CW'(RSP_DEPTH));
    assign busy_sel    = bank ? mem.DRam0BusyB1 : mem.DRam0BusyB0;
    assign en          = req.req_valid && credit_ok && !BReset;
    assign accept      = req.req_valid && req.req_ready;

    assign req.req_ready = credit_ok && !busy_sel && !BReset;

    assign mem.DRam0EnB0     = en && !bank;
    assign mem.DRam0EnB1     = en && bank;
    assign mem.DRam0AddrB0   = row;
    assign mem.DRam0AddrB1   = row;
    assign mem.DRam0WrB0     = req.req_write && !BReset;
    assign mem.DRam0WrB1     = req.req_write && !BReset;
    assign mem.DRam0ByteEnB0 = req.req_write ? req.req_byte_en : '0;
    assign mem.DRam0ByteEnB1 = req.req_write ? req.req_byte_en : '0;
    assign mem.DRam0WrDataB0 = req.req_wdata;
    assign mem.DRam0WrDataB1 = req.req_wdata;

    assign push      = s2_q;
    assign push_data = t2_q ? mem.DRam0DataB1 : mem.DRam0DataB0;
    assign pop       = req.rsp_ready && (count_q != '0);

    assign req.rsp_valid = (count_q != '0);
    assign req.rsp_data  = fifo_q[rd_ptr_q];

    // Two-stage tracker matching the memory's fixed read latency.
    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            t1_q <= 1'b0;
            t2_q <= 1'b0;
        end else begin
            s1_q <= accept && !req.req_write;
            t1_q <= bank;
            s2_q <= s1_q;
            t2_q <= t1_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
            end
        end
    end

    push_when_full_a: assert property (@(posedge CLK) disable iff (BReset)
        !(push && (count_q == CW'(RSP_DEPTH))));

endmodule
